// File: rtl/bounce_box_renderer.sv
// rtl/bounce_box_renderer.sv - checkerboard pixel source with a bouncing solid box
// Every output, sync included, is registered once so the panel sees an aligned stream.
module bounce_box_renderer #(
   parameter int H_ACTIVE = 800,
   parameter int V_ACTIVE = 480,
   parameter int BOX_W    = 64,
   parameter int BOX_H    = 48,
   parameter int STEP     = 2
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic [9:0] X,
   input  logic [9:0] Y,
   input  logic       DE,
   input  logic       HSYNC,
   input  logic       VSYNC,
   input  logic       PAUSE,
   output logic       DE_O,
   output logic       HSYNC_O,
   output logic       VSYNC_O,
   output logic [4:0] R,
   output logic [5:0] G,
   output logic [4:0] B,
   output logic       HIT
);

   localparam logic [10:0] XMAX     = 11'(H_ACTIVE - BOX_W);
   localparam logic [10:0] YMAX     = 11'(V_ACTIVE - BOX_H);
   localparam logic [10:0] STP      = 11'(STEP);
   localparam logic [10:0] LAST_ROW = 11'(V_ACTIVE - 1);

   logic [10:0] pos_x, pos_y;
   logic        dir_x, dir_y;
   logic [2:0]  cidx;
   logic        de_q;

   logic        tick;
   logic        in_box;
   logic [10:0] x_ext, y_ext;
   logic [12:0] nx, ny;
   logic        hit_any;
   logic [4:0]  pix_r, pix_b;
   logic [5:0]  pix_g;

   // Returns {hit, new_dir, new_pos}; dir=1 means moving toward larger coordinates.
   function automatic logic [12:0] step_axis(input logic [10:0] pos, input logic dir,
                                             input logic [10:0] lim);
      logic [12:0] res;
      res = {1'b0, dir, pos};
      if (dir) begin
         if (pos + STP > lim) res = {1'b1, 1'b0, lim};
         else                 res = {1'b0, 1'b1, pos + STP};
      end else begin
         if (pos < STP)       res = {1'b1, 1'b1, 11'd0};
         else                 res = {1'b0, 1'b0, pos - STP};
      end
      return res;
   endfunction

   assign x_ext   = {1'b0, X};
   assign y_ext   = {1'b0, Y};
   // Falling DE on the last active line: position moves during blanking.
   assign tick    = de_q && !DE && (y_ext == LAST_ROW);
   assign nx      = step_axis(pos_x, dir_x, XMAX);
   assign ny      = step_axis(pos_y, dir_y, YMAX);
   assign hit_any = nx[12] || ny[12];
   assign in_box  = (x_ext >= pos_x) && (x_ext < pos_x + 11'(BOX_W)) &&
                    (y_ext >= pos_y) && (y_ext < pos_y + 11'(BOX_H));
   assign DE_O    = de_q;

   always_comb begin
      pix_r = 5'd0;
      pix_g = 6'd0;
      pix_b = 5'd0;
      if (DE) begin
         if (in_box) begin
            pix_r = cidx[2] ? 5'd31 : 5'd0;
            pix_g = cidx[1] ? 6'd63 : 6'd0;
            pix_b = cidx[0] ? 5'd31 : 5'd0;
         end else if (X[5] ^ Y[5]) begin
            pix_g = 6'd8;
            pix_b = 5'd12;
         end else begin
            pix_b = 5'd4;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         pos_x   <= '0;
         pos_y   <= '0;
         dir_x   <= 1'b1;
         dir_y   <= 1'b1;
         cidx    <= 3'd7;
         de_q    <= 1'b0;
         HSYNC_O <= 1'b0;
         VSYNC_O <= 1'b0;
         R       <= '0;
         G       <= '0;
         B       <= '0;
         HIT     <= 1'b0;
      end else begin
         de_q    <= DE;
         HSYNC_O <= HSYNC;
         VSYNC_O <= VSYNC;
         R       <= pix_r;
         G       <= pix_g;
         B       <= pix_b;
         HIT     <= 1'b0;
         if (tick && !PAUSE) begin
            pos_x <= nx[10:0];
            dir_x <= nx[11];
            pos_y <= ny[10:0];
            dir_y <= ny[11];
            // A corner hit still advances the colour only once.
            if (hit_any) begin
               HIT  <= 1'b1;
               cidx <= (cidx == 3'd7) ? 3'd1 : cidx + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bounce_box_renderer.sv
// tb/tb_bounce_box_renderer.sv - scoreboard bench for bounce_box_renderer (default and corner-sized instances)
module tb_bounce_box_renderer;

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      logic       hit;
   } out_t;

   logic       clk = 1'b0;
   logic       nrst;
   logic [9:0] xi[2], yi[2];
   logic       dei[2], hsi[2], vsi[2], pausei[2];
   logic       de_o[2], hs_o[2], vs_o[2], hit_o[2];
   logic [4:0] r_o[2], b_o[2];
   logic [5:0] g_o[2];

   always #5 clk = ~clk;

   bounce_box_renderer u_dut0 (
      .CLK(clk), .nRST(nrst), .X(xi[0]), .Y(yi[0]), .DE(dei[0]), .HSYNC(hsi[0]),
      .VSYNC(vsi[0]), .PAUSE(pausei[0]), .DE_O(de_o[0]), .HSYNC_O(hs_o[0]),
      .VSYNC_O(vs_o[0]), .R(r_o[0]), .G(g_o[0]), .B(b_o[0]), .HIT(hit_o[0]));

   bounce_box_renderer #(.H_ACTIVE(40), .V_ACTIVE(40), .BOX_W(8), .BOX_H(8), .STEP(4)) u_dut1 (
      .CLK(clk), .nRST(nrst), .X(xi[1]), .Y(yi[1]), .DE(dei[1]), .HSYNC(hsi[1]),
      .VSYNC(vsi[1]), .PAUSE(pausei[1]), .DE_O(de_o[1]), .HSYNC_O(hs_o[1]),
      .VSYNC_O(vs_o[1]), .R(r_o[1]), .G(g_o[1]), .B(b_o[1]), .HIT(hit_o[1]));

   int PH[2]  = '{800, 40};
   int PV[2]  = '{480, 40};
   int PBW[2] = '{64, 8};
   int PBH[2] = '{48, 8};
   int PST[2] = '{2, 4};

   int px[2], py[2], ci[2];
   bit dx[2], dy[2], deq[2];

   out_t exp_q[$];
   out_t obs;
   int   vectors = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic axis(inout int p, inout bit dir, input int mx, input int st, output bit h);
      h = 1'b0;
      if (dir) begin
         if (p + st > mx) begin p = mx; dir = 1'b0; h = 1'b1; end
         else p = p + st;
      end else begin
         if (p < st) begin p = 0; dir = 1'b1; h = 1'b1; end
         else p = p - st;
      end
   endtask

   task automatic cyc(input int d, input bit rn, input int x, input int y, input bit de,
                      input bit hs, input bit vs, input bit pause);
      out_t e;
      bit   hx, hy;
      int   c;
      @(negedge clk);
      nrst = rn;
      for (int k = 0; k < 2; k++) begin
         xi[k] = '0; yi[k] = '0; dei[k] = 1'b0; hsi[k] = 1'b0; vsi[k] = 1'b0; pausei[k] = 1'b0;
      end
      xi[d] = 10'(x); yi[d] = 10'(y); dei[d] = de; hsi[d] = hs; vsi[d] = vs; pausei[d] = pause;
      e = '0;
      if (!rn) begin
         for (int k = 0; k < 2; k++) begin
            px[k] = 0; py[k] = 0; dx[k] = 1'b1; dy[k] = 1'b1; ci[k] = 7; deq[k] = 1'b0;
         end
      end else begin
         e.de = de; e.hs = hs; e.vs = vs;
         if (de) begin
            if (x >= px[d] && x < px[d] + PBW[d] && y >= py[d] && y < py[d] + PBH[d]) begin
               c = ci[d];
               e.r = c[2] ? 5'd31 : 5'd0;
               e.g = c[1] ? 6'd63 : 6'd0;
               e.b = c[0] ? 5'd31 : 5'd0;
            end else if ((((x >> 5) ^ (y >> 5)) & 1) == 1) begin
               e.g = 6'd8; e.b = 5'd12;
            end else begin
               e.b = 5'd4;
            end
         end
         if (deq[d] && !de && y == PV[d] - 1 && !pause) begin
            axis(px[d], dx[d], PH[d] - PBW[d], PST[d], hx);
            axis(py[d], dy[d], PV[d] - PBH[d], PST[d], hy);
            if (hx || hy) begin
               e.hit = 1'b1;
               ci[d] = (ci[d] == 7) ? 1 : ci[d] + 1;
            end
         end
         deq[d] = de;
         deq[1-d] = 1'b0;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      obs = {de_o[d], hs_o[d], vs_o[d], r_o[d], g_o[d], b_o[d], hit_o[d]};
      check($sformatf("out%0d", d), 32'(obs), 32'(exp_q.pop_front()));
   endtask

   task automatic tick(input int d, input bit pause, output bit h);
      cyc(d, 1'b1, 0, PV[d] - 1, 1'b1, 1'b0, 1'b0, pause);
      cyc(d, 1'b1, 0, PV[d] - 1, 1'b0, 1'b0, 1'b0, pause);
      h = obs.hit;
   endtask

   initial begin
      int hits[$];
      bit h;
      int n;

      nrst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         xi[k] = '0; yi[k] = '0; dei[k] = 1'b0; hsi[k] = 1'b0; vsi[k] = 1'b0; pausei[k] = 1'b0;
      end

      for (int i = 0; i < 4; i++) cyc(0, 1'b0, 10, 10, 1'(i % 2), 1'b1, 1'b1, 1'b0);
      check("reset_out", 32'(obs), 32'd0);
      cyc(0, 1'b1, 10, 10, 1'b1, 1'b0, 1'b0, 1'b0);
      check("white_box", {r_o[0], g_o[0], b_o[0]}, {5'd31, 6'd63, 5'd31});
      cyc(0, 1'b1, 96, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("bg_light", {r_o[0], g_o[0], b_o[0]}, {5'd0, 6'd8, 5'd12});
      cyc(0, 1'b1, 96, 32, 1'b1, 1'b0, 1'b0, 1'b0);
      check("bg_dark", {r_o[0], g_o[0], b_o[0]}, {5'd0, 6'd0, 5'd4});
      cyc(0, 1'b1, 96, 32, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(0, 1'b1, 200, 5, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(0, 1'b1, 200, 5, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(0, 1'b1, 200, 5, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int t = 1; t <= 370; t++) begin
         tick(0, 1'b0, h);
         if (h) hits.push_back(t);
         if (t == 368) begin
            cyc(0, 1'b1, 736, 130, 1'b1, 1'b0, 1'b0, 1'b0);
            check("edge_blue", {r_o[0], g_o[0], b_o[0]}, {5'd0, 6'd0, 5'd31});
            cyc(0, 1'b1, 735, 130, 1'b1, 1'b0, 1'b0, 1'b0);
         end
         if (t == 369) begin
            cyc(0, 1'b1, 740, 130, 1'b1, 1'b0, 1'b0, 1'b0);
            check("green_box", {r_o[0], g_o[0], b_o[0]}, {5'd0, 6'd63, 5'd0});
         end
      end
      check("n_hits", hits.size(), 2);
      check("hit1_tick", (hits.size() > 0) ? hits[0] : -1, 217);
      check("hit2_tick", (hits.size() > 1) ? hits[1] : -1, 369);

      for (int i = 0; i < 200; i++)
         cyc(0, 1'b1, $urandom_range(0, 1023),
             ($urandom_range(0, 3) == 0) ? 479 : $urandom_range(0, 1023),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));

      n = 0;
      for (int t = 0; t < 5; t++) begin
         tick(0, 1'b1, h);
         if (h) n++;
         cyc(0, 1'b1, px[0], py[0], 1'b1, 1'b0, 1'b0, 1'b1);
      end
      check("pause_hits", n, 0);

      cyc(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int t = 0; t < 100; t++) tick(0, 1'b0, h);
      cyc(0, 1'b1, 300, 200, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(0, 1'b0, 300, 201, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rst_box_00", {r_o[0], g_o[0], b_o[0]}, {5'd31, 6'd63, 5'd31});
      cyc(0, 1'b1, 63, 47, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rst_box_63_47", {r_o[0], g_o[0], b_o[0]}, {5'd31, 6'd63, 5'd31});
      cyc(0, 1'b1, 64, 47, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(0, 1'b1, 63, 48, 1'b1, 1'b0, 1'b0, 1'b0);

      hits.delete();
      cyc(1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int t = 1; t <= 10; t++) begin
         tick(1, 1'b0, h);
         if (h) hits.push_back(t);
      end
      check("corner_n_hits", hits.size(), 1);
      check("corner_tick", (hits.size() > 0) ? hits[0] : -1, 9);
      cyc(1, 1'b1, 32, 32, 1'b1, 1'b0, 1'b0, 1'b0);
      check("corner_blue", {r_o[1], g_o[1], b_o[1]}, {5'd0, 6'd0, 5'd31});
      cyc(1, 1'b1, 27, 32, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
